// File: rtl/scoreboard_hazard_unit_if.sv
// Bundle between the ID/EX pipeline stages and the load-use scoreboard.
// The master side drives decode/execute state; the slave side (the hazard
// unit) returns the combinational stall request.
interface scoreboard_hazard_unit_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ID_ADDR1;
    logic [ADDR_WIDTH-1:0] ID_ADDR2;
    logic                  ID_OPERAND1_SELECT;
    logic                  ID_OPERAND2_SELECT;
    logic [ADDR_WIDTH-1:0] EX_REG_WRITE_ADDR;
    logic                  EX_DATA_MEM_READ;
    logic                  EX_VALID;
    logic                  FLUSH;
    logic                  MEM_BUSY;
    logic                  LU_HAZ_SIG;

    modport master (
        output ID_ADDR1, ID_ADDR2, ID_OPERAND1_SELECT, ID_OPERAND2_SELECT,
               EX_REG_WRITE_ADDR, EX_DATA_MEM_READ, EX_VALID, FLUSH, MEM_BUSY,
        input  LU_HAZ_SIG
    );

    modport slave (
        input  ID_ADDR1, ID_ADDR2, ID_OPERAND1_SELECT, ID_OPERAND2_SELECT,
               EX_REG_WRITE_ADDR, EX_DATA_MEM_READ, EX_VALID, FLUSH, MEM_BUSY,
        output LU_HAZ_SIG
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Load-use hazard detector with a per-register countdown scoreboard.
// Each in-flight load arms a counter for its destination register; an ID
// operand reading that register stalls while the count is 2 or more (a count
// of 1 means the value is forwardable). A load sitting in EX this cycle is
// covered directly by the ex_match path so there is no one-cycle gap.
// Optional feature: define HAZ_STALL_CNT_EN to add the saturating
// STALL_COUNT output; without it the port and counter do not exist.
module scoreboard_hazard_unit #(
    parameter int ADDR_WIDTH      = 5,
    parameter int LOAD_LATENCY    = 2,
    parameter int CNT_WIDTH       = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
`ifdef HAZ_STALL_CNT_EN
    output logic [STALL_CNT_WIDTH-1:0] STALL_COUNT,
`endif
    scoreboard_hazard_unit_if.slave    bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
    logic                 ex_load;
    logic                 issue;

    // A still-pending load result that cannot yet be forwarded.
    function automatic logic pend(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (cnt_q[a] >= CNT_WIDTH'(2));
    endfunction

    // The dependent instruction meets the load while it is still in EX.
    function automatic logic ex_match(input logic [ADDR_WIDTH-1:0] a);
        return ex_load && (a != '0) && (a == bus.EX_REG_WRITE_ADDR);
    endfunction

    // Qualify the EX-stage load and decide whether it is recorded.
    always_comb begin
        ex_load = bus.EX_DATA_MEM_READ & bus.EX_VALID & ~bus.FLUSH;
        issue   = ex_load & (bus.EX_REG_WRITE_ADDR != '0);
    end

    // Next countdown per register: issue reloads, otherwise tick unless memory is busy.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && (bus.EX_REG_WRITE_ADDR == ADDR_WIDTH'(r))) begin
                cnt_d[r] = CNT_WIDTH'(LOAD_LATENCY);
            end else if (!bus.MEM_BUSY && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
            end
        end
    end

    // Scoreboard state; reset forgets every in-flight load.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Stall request for either register-file operand.
    always_comb begin
        bus.LU_HAZ_SIG =
            (~bus.ID_OPERAND1_SELECT & (ex_match(bus.ID_ADDR1) | pend(bus.ID_ADDR1))) |
            (~bus.ID_OPERAND2_SELECT & (ex_match(bus.ID_ADDR2) | pend(bus.ID_ADDR2)));
    end

`ifdef HAZ_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    // Count stalled cycles, holding at all-ones once saturated.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
        end else if (bus.LU_HAZ_SIG && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign STALL_COUNT = stall_cnt_q;
`endif
endmodule
